lc3_mem_unit: RTL

- Parametrised successor to the single-cycle RAM on the LC-3 datapath: word-addressed memory with a configurable wait-state count and a real READY handshake.
- Adds LC-3 memory-mapped I/O: KBSR/KBDR keyboard and DSR/DDR display.
- Connects to MAR (ADDR), MDR (DataIn, out) and the control FSM (CS = MIO_EN, WE, READY).

---
 rtl/lc3_mem_unit_if.sv | 15 +
 rtl/lc3_mem_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/lc3_mem_unit_if.sv
// Request/response bus between the LC-3 control path (MAR/MDR/FSM) and the memory unit.
interface lc3_mem_unit_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              CS;
  logic              WE;
  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] DataIn;
  logic [DATA_W-1:0] out;
  logic              READY;

  modport master (output CS, WE, ADDR, DataIn, input out, READY);
  modport slave  (input CS, WE, ADDR, DataIn, output out, READY);
endinterface

// File: rtl/lc3_mem_unit.sv
// LC-3 memory unit: word RAM with configurable wait states and a READY pulse,
// plus memory-mapped keyboard (KBSR/KBDR) and display (DSR/DDR) registers.
module lc3_mem_unit #(
  parameter int              DATA_W  = 16,
  parameter int              ADDR_W  = 16,
  parameter int              DEPTH   = 1024,
  parameter int              LATENCY = 3,
  parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'('hFE00),
  parameter logic [ADDR_W-1:0] KBSR_A  = ADDR_W'('hFE00),
  parameter logic [ADDR_W-1:0] KBDR_A  = ADDR_W'('hFE02),
  parameter logic [ADDR_W-1:0] DSR_A   = ADDR_W'('hFE04),
  parameter logic [ADDR_W-1:0] DDR_A   = ADDR_W'('hFE06)
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  lc3_mem_unit_if.slave        bus,
  input  logic [7:0]           KB_DATA,
  input  logic                 KB_VALID,
  output logic                 KB_ACK,
  output logic                 KB_IRQ,
  output logic [7:0]           DISP_DATA,
  output logic                 DISP_VALID,
  input  logic                 DISP_READY
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic                accept, commit;

  logic [ADDR_W-1:0]   a_addr;
  logic                a_we;
  logic [DATA_W-1:0]   a_data;
  logic [DATA_W-1:0]   out_q;

  logic [ADDR_W-1:0]   c_addr;
  logic                c_we;
  logic [DATA_W-1:0]   c_data;

  logic                kb_flag, kb_ie, kb_ack;
  logic [7:0]          kbdr;
  logic                dsr_rdy;
  logic [7:0]          disp_data;
  logic                disp_valid;

  logic [DATA_W-1:0]   ram [DEPTH];

  logic                is_io;
  logic [15:0]         io_rd;
  logic [DATA_W-1:0]   rd_data;
  logic                ram_we, kbsr_wr, ddr_wr, kbdr_rd, kb_capture;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    commit  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.CS) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            commit  = 1'b1;
            state_n = ST_DONE;
          end else begin
            cnt_n   = CNT_W'(LATENCY);
            state_n = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          commit  = 1'b1;
          state_n = ST_DONE;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // With zero wait states the commit happens on the accepting edge, so take the live bus.
  always_comb begin
    c_addr = (state == ST_IDLE) ? bus.ADDR   : a_addr;
    c_we   = (state == ST_IDLE) ? bus.WE     : a_we;
    c_data = (state == ST_IDLE) ? bus.DataIn : a_data;
  end

  always_comb begin
    is_io = (c_addr >= IO_BASE);
    io_rd = '0;
    if (c_addr == KBSR_A)      io_rd = {kb_flag, kb_ie, 14'd0};
    else if (c_addr == KBDR_A) io_rd = {8'd0, kbdr};
    else if (c_addr == DSR_A)  io_rd = {dsr_rdy, 15'd0};
    rd_data = is_io ? DATA_W'(io_rd) : ram[c_addr[AW-1:0]];
  end

  assign ram_we     = commit & c_we & ~is_io & RST_N;
  assign kbsr_wr    = commit & c_we & is_io & (c_addr == KBSR_A);
  assign ddr_wr     = commit & c_we & is_io & (c_addr == DDR_A);
  assign kbdr_rd    = commit & ~c_we & is_io & (c_addr == KBDR_A);
  // A KBDR read completing this edge owns the flag; a waiting keystroke is taken next cycle.
  assign kb_capture = KB_VALID & ~kb_flag & ~kbdr_rd;

  // NOTE: RAM has no reset; a memory array cannot be cleared in one cycle and software never relies on it.
  always_ff @(posedge CLK) begin
    if (ram_we) ram[c_addr[AW-1:0]] <= c_data;
  end

  // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      a_addr     <= '0;
      a_we       <= 1'b0;
      a_data     <= '0;
      out_q      <= '0;
      kb_flag    <= 1'b0;
      kb_ie      <= 1'b0;
      kbdr       <= '0;
      kb_ack     <= 1'b0;
      dsr_rdy    <= 1'b1;
      disp_data  <= '0;
      disp_valid <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      kb_ack <= kb_capture;
      if (accept) begin
        a_addr <= bus.ADDR;
        a_we   <= bus.WE;
        a_data <= bus.DataIn;
      end
      if (commit && !c_we) out_q <= rd_data;

      if (kbdr_rd) begin
        kb_flag <= 1'b0;
      end else if (kb_capture) begin
        kb_flag <= 1'b1;
        kbdr    <= KB_DATA;
      end
      if (kbsr_wr) kb_ie <= c_data[14];

      // A DDR write on the same edge as a consume keeps the new character pending.
      if (ddr_wr) begin
        disp_data  <= c_data[7:0];
        disp_valid <= 1'b1;
        dsr_rdy    <= 1'b0;
      end else if (disp_valid && DISP_READY) begin
        disp_valid <= 1'b0;
        dsr_rdy    <= 1'b1;
      end
    end
  end

  assign bus.out    = out_q;
  assign bus.READY  = (state == ST_DONE);
  assign KB_ACK     = kb_ack;
  assign KB_IRQ     = kb_flag & kb_ie;
  assign DISP_DATA  = disp_data;
  assign DISP_VALID = disp_valid;

endmodule
